s_port_alloc_ctrl: RTL and testbench
====================================

Name: s_port_alloc_ctrl

Overview:
- Sequencing controller for the south output port.
- Samples the one-hot grant from s_rr_processor and locks that input to the south output for a whole wormhole packet, head through tail.
- Tracks downstream buffer credits and drives rr_downstream_credit into the arbiter.
- Pulses the arbiter's change-order input once per completed packet, so round-robin rotation happens on packet boundaries, not on every flit.

Parameters:
- CREDITS, 4: downstream input-buffer depth in flits; credit counter reset value and maximum.
- CW, 3: credit counter width; must satisfy 2**CW > CREDITS.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid_i  in  4  per-input flit-valid toward south, order {n,w,e,l}
- req_tail_i  in  4  per-input tail flag of the current flit, same order
- rrp_grant_i  in  4  arbiter one-hot grant {n,w,e,l} (rrp_s_priority_*_o)
- credit_return_i  in  1  one credit returned by the downstream router this cycle
- rr_change_order_o  out  1  one-cycle pulse to the arbiter's change_order input
- rr_downstream_credit_o  out  1  to the arbiter's rr_downstream_credit input; 1 when credit_cnt != 0
- grant_o  out  4  per-input pop strobe; flit transferred this cycle
- xbar_sel_o  out  3  crossbar select for the south output (package encoding)
- flit_valid_o  out  1  flit valid toward downstream; equals |grant_o
- credit_cnt_o  out  CW  current credit count
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values (asynchronous, active-high):
  - state=IDLE, owner=none, xbar_sel_o=SEL_NONE, credit_cnt=CREDITS
  - rr_change_order_o=0, err_o=0, grant_o=0, flit_valid_o=0
- IDLE state:
  - grant_o=0.
  - If rrp_grant_i != 0, latch owner = granted index and xbar_sel_o = port code on the clock edge; go to LOCKED.
  - If more than one bit of rrp_grant_i is set, choose by fixed priority n>w>e>l and set err_o.
- LOCKED state:
  - grant_o[owner] = req_valid_i[owner] & (credit_cnt != 0), combinational; all other grant_o bits are 0.
  - Transfer with req_tail_i[owner]=1: go to RELEASE.
  - Owner's valid drops mid-packet: stay LOCKED, no transfer (bubble); the lock is held indefinitely.
  - rrp_grant_i is ignored while LOCKED.
- RELEASE state (exactly one cycle):
  - rr_change_order_o=1 (registered output, high only in this cycle), owner cleared, xbar_sel_o=SEL_NONE, grant_o=0, then go to IDLE.
  - The arbiter's new order is visible in the following IDLE cycle.
- Latency:
  - Grant sampled at edge k; first flit transfer possible in cycle k+1.
  - A single-flit packet (head=tail) occupies LOCKED for 1 cycle and RELEASE for 1 cycle, giving a minimum of 3 cycles per packet per port.
- Credit counter:
  - Decrements on flit_valid_o and increments on credit_return_i; both in the same cycle leaves it unchanged.
  - Never decrements below 0, because grant is gated by credit != 0.
  - credit_return_i while credit_cnt==CREDITS (with no simultaneous send): count holds at CREDITS and err_o is set.
- rr_downstream_credit_o = (credit_cnt != 0), taken from the register, with no dependency on credit_return_i in the same cycle.
- err_o clears only on reset.
- Reset mid-packet: all state returns to reset values immediately; a partial packet is abandoned, and upstream recovery is outside this block.

Decomposition:
- Shared package noc_pkg:
  - Port select codes: SEL_N=3'd0, SEL_S=3'd1, SEL_W=3'd2, SEL_E=3'd3, SEL_L=3'd4, SEL_NONE=3'd7.
  - typedef enum logic [1:0] {IDLE, LOCKED, RELEASE} alloc_state_t.
  - Request bit-index constants: IDX_N=3, IDX_W=2, IDX_E=1, IDX_L=0.
- Sub-module credit_counter (parameters CREDITS, CW; ports clk, reset, dec_i, inc_i, cnt_o, nonzero_o, overflow_o). It is reusable by the other four output-port controllers.

Test Plan:
1. Reset, then rrp_grant_i=4'b1000 with a 3-flit packet on n (valid every cycle, tail on flit 3) -> LOCKED next cycle; grant_o=4'b1000 for 3 cycles; xbar_sel_o=SEL_N; credit_cnt goes 4→1; rr_change_order_o=1 for exactly one cycle afterward; xbar_sel_o=SEL_NONE.
2. CREDITS=4, no returns, 6-flit packet on w -> 4 transfers, then grant_o=0 and rr_downstream_credit_o=0. One credit_return_i -> exactly one more transfer in the following cycle.
3. Simultaneous send and credit_return_i at credit_cnt=2 -> credit_cnt stays 2. credit_return_i at credit_cnt=4 with no send -> stays 4, err_o=1 and remains 1 until reset.
4. Bubble mid-packet (l valid 1,0,0,1-tail) while rrp_grant_i toggles to e -> owner stays l, no e transfer; release only after the l tail.
5. rrp_grant_i=4'b0110 in IDLE -> owner=w, xbar_sel_o=SEL_W, err_o=1.
6. reset asserted asynchronously mid-packet (between edges) -> outputs return to reset values before the next edge; credit_cnt=4, no rr_change_order_o pulse.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: crossbar select codes, allocator states and the
// request-vector bit positions ({n,w,e,l}) used by every output-port controller.
package noc_pkg;

  localparam logic [2:0] SEL_N    = 3'd0;
  localparam logic [2:0] SEL_S    = 3'd1;
  localparam logic [2:0] SEL_W    = 3'd2;
  localparam logic [2:0] SEL_E    = 3'd3;
  localparam logic [2:0] SEL_L    = 3'd4;
  localparam logic [2:0] SEL_NONE = 3'd7;

  typedef enum logic [1:0] {IDLE, LOCKED, RELEASE} alloc_state_t;

  localparam int IDX_N = 3;
  localparam int IDX_W = 2;
  localparam int IDX_E = 1;
  localparam int IDX_L = 0;

  // Fixed-priority n > w > e > l reduction of a possibly multi-hot grant.
  function automatic logic [3:0] pick_one(input logic [3:0] g);
    logic [3:0] oh;
    oh = '0;
    if (g[IDX_N])      oh[IDX_N] = 1'b1;
    else if (g[IDX_W]) oh[IDX_W] = 1'b1;
    else if (g[IDX_E]) oh[IDX_E] = 1'b1;
    else if (g[IDX_L]) oh[IDX_L] = 1'b1;
    return oh;
  endfunction

  function automatic logic [2:0] sel_of(input logic [3:0] g);
    if (g[IDX_N])      return SEL_N;
    else if (g[IDX_W]) return SEL_W;
    else if (g[IDX_E]) return SEL_E;
    else if (g[IDX_L]) return SEL_L;
    else               return SEL_NONE;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Downstream credit counter shared by all output-port controllers; saturates at
// CREDITS and flags a return that arrives while already full.
module credit_counter #(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          nonzero_o,
  output logic          overflow_o
);

  localparam logic [CW-1:0] MAX = CW'(CREDITS);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d      = cnt_q;
    overflow_o = inc_i & ~dec_i & (cnt_q == MAX);
    if (dec_i && !inc_i && cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
    else if (inc_i && !dec_i && cnt_q != MAX)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= MAX;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/s_port_alloc_ctrl.sv
// South output-port sequencer: holds the arbiter's chosen input for a whole
// wormhole packet, gates flits on downstream credit, rotates order per packet.
module s_port_alloc_ctrl import noc_pkg::*; #(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    req_valid_i,
  input  logic [3:0]    req_tail_i,
  input  logic [3:0]    rrp_grant_i,
  input  logic          credit_return_i,
  output logic          rr_change_order_o,
  output logic          rr_downstream_credit_o,
  output logic [3:0]    grant_o,
  output logic [2:0]    xbar_sel_o,
  output logic          flit_valid_o,
  output logic [CW-1:0] credit_cnt_o,
  output logic          err_o
);

  alloc_state_t state_q, state_d;
  logic [3:0]   owner_q, owner_d;
  logic [2:0]   sel_q, sel_d;
  logic         co_q, co_d;
  logic         err_q, err_d;
  logic [3:0]   grant;
  logic         credit_nz, credit_ovf;

  credit_counter #(.CREDITS(CREDITS), .CW(CW)) u_credit (
    .clk        (clk),
    .reset      (reset),
    .dec_i      (flit_valid_o),
    .inc_i      (credit_return_i),
    .cnt_o      (credit_cnt_o),
    .nonzero_o  (credit_nz),
    .overflow_o (credit_ovf)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    co_d    = 1'b0;
    err_d   = err_q | credit_ovf;
    grant   = '0;
    case (state_q)
      IDLE: begin
        if (rrp_grant_i != '0) begin
          owner_d = pick_one(rrp_grant_i);
          sel_d   = sel_of(rrp_grant_i);
          state_d = LOCKED;
          if ((rrp_grant_i & (rrp_grant_i - 4'd1)) != '0) err_d = 1'b1;
        end
      end
      LOCKED: begin
        // Credit gating keeps the counter from ever underflowing.
        grant = credit_nz ? (owner_q & req_valid_i) : '0;
        if ((grant & req_tail_i) != '0) begin
          state_d = RELEASE;
          owner_d = '0;
          sel_d   = SEL_NONE;
          co_d    = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      sel_q   <= SEL_NONE;
      co_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      co_q    <= co_d;
      err_q   <= err_d;
    end
  end

  assign grant_o                = grant;
  assign flit_valid_o           = |grant;
  assign xbar_sel_o             = sel_q;
  assign rr_change_order_o      = co_q;
  assign rr_downstream_credit_o = credit_nz;
  assign err_o                  = err_q;

endmodule

// File: tb/tb_s_port_alloc_ctrl.sv
// Directed bench for the south-port allocator: expected per-cycle outputs are
// queued with each stimulus step and popped when the DUT outputs are sampled.
module tb_s_port_alloc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid_i, req_tail_i, rrp_grant_i;
  logic       credit_return_i;
  logic       rr_change_order_o, rr_downstream_credit_o, flit_valid_o, err_o;
  logic [3:0] grant_o;
  logic [2:0] xbar_sel_o;
  logic [2:0] credit_cnt_o;

  typedef struct {
    string      tag;
    logic [3:0] g;
    logic [2:0] sel;
    logic       co;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  s_port_alloc_ctrl #(.CREDITS(4), .CW(3)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .req_valid_i            (req_valid_i),
    .req_tail_i             (req_tail_i),
    .rrp_grant_i            (rrp_grant_i),
    .credit_return_i        (credit_return_i),
    .rr_change_order_o      (rr_change_order_o),
    .rr_downstream_credit_o (rr_downstream_credit_o),
    .grant_o                (grant_o),
    .xbar_sel_o             (xbar_sel_o),
    .flit_valid_o           (flit_valid_o),
    .credit_cnt_o           (credit_cnt_o),
    .err_o                  (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nchk++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input string tag, input logic [3:0] g, input logic [2:0] sel,
                          input logic co, input logic [2:0] cnt, input logic err);
    exp_t e;
    e.tag = tag; e.g = g; e.sel = sel; e.co = co; e.cnt = cnt; e.err = err;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".grant"},  32'(grant_o),                e.g);
    chk({e.tag, ".fvld"},   32'(flit_valid_o),           32'(|e.g));
    chk({e.tag, ".sel"},    32'(xbar_sel_o),             e.sel);
    chk({e.tag, ".chg"},    32'(rr_change_order_o),      e.co);
    chk({e.tag, ".cnt"},    32'(credit_cnt_o),           e.cnt);
    chk({e.tag, ".dscred"}, 32'(rr_downstream_credit_o), 32'(e.cnt != 3'd0));
    chk({e.tag, ".err"},    32'(err_o),                  e.err);
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, then advance.
  task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] t,
                     input logic [3:0] g, input logic cr, input logic [3:0] eg,
                     input logic [2:0] es, input logic eco, input logic [2:0] ecnt,
                     input logic eerr);
    req_valid_i = v; req_tail_i = t; rrp_grant_i = g; credit_return_i = cr;
    push_exp(tag, eg, es, eco, ecnt, eerr);
    #1;
    compare_front();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid_i = '0; req_tail_i = '0; rrp_grant_i = '0; credit_return_i = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid_i = '0; req_tail_i = '0; rrp_grant_i = '0; credit_return_i = 1'b0;
    @(negedge clk);
    push_exp("rst", 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);
    #1;
    compare_front();
    @(negedge clk);
    reset = 1'b0;

    // 3-flit packet on n
    cyc("t1_req",  4'h0, 4'h0, 4'h8, 1'b0, 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);
    cyc("t1_f1",   4'h8, 4'h0, 4'h0, 1'b0, 4'h8, 3'd0, 1'b0, 3'd4, 1'b0);
    cyc("t1_f2",   4'h8, 4'h0, 4'h0, 1'b0, 4'h8, 3'd0, 1'b0, 3'd3, 1'b0);
    cyc("t1_f3",   4'h8, 4'h8, 4'h0, 1'b0, 4'h8, 3'd0, 1'b0, 3'd2, 1'b0);
    cyc("t1_rel",  4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd7, 1'b1, 3'd1, 1'b0);
    cyc("t1_idle", 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 3'd7, 1'b0, 3'd1, 1'b0);
    cyc("t1_ret2", 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 3'd7, 1'b0, 3'd2, 1'b0);
    cyc("t1_ret3", 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 3'd7, 1'b0, 3'd3, 1'b0);
    cyc("t1_full", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);

    // 6-flit packet on w with credit starvation
    cyc("t2_req",  4'h0, 4'h0, 4'h4, 1'b0, 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);
    cyc("t2_f1",   4'h4, 4'h0, 4'h0, 1'b0, 4'h4, 3'd2, 1'b0, 3'd4, 1'b0);
    cyc("t2_f2",   4'h4, 4'h0, 4'h0, 1'b0, 4'h4, 3'd2, 1'b0, 3'd3, 1'b0);
    cyc("t2_f3",   4'h4, 4'h0, 4'h0, 1'b0, 4'h4, 3'd2, 1'b0, 3'd2, 1'b0);
    cyc("t2_f4",   4'h4, 4'h0, 4'h0, 1'b0, 4'h4, 3'd2, 1'b0, 3'd1, 1'b0);
    cyc("t2_st1",  4'h4, 4'h0, 4'h0, 1'b0, 4'h0, 3'd2, 1'b0, 3'd0, 1'b0);
    cyc("t2_st2",  4'h4, 4'h0, 4'h0, 1'b0, 4'h0, 3'd2, 1'b0, 3'd0, 1'b0);
    cyc("t2_ret",  4'h4, 4'h0, 4'h0, 1'b1, 4'h0, 3'd2, 1'b0, 3'd0, 1'b0);
    cyc("t2_f5",   4'h4, 4'h0, 4'h0, 1'b0, 4'h4, 3'd2, 1'b0, 3'd1, 1'b0);
    cyc("t2_ret2", 4'h4, 4'h0, 4'h0, 1'b1, 4'h0, 3'd2, 1'b0, 3'd0, 1'b0);
    cyc("t2_f6",   4'h4, 4'h4, 4'h0, 1'b0, 4'h4, 3'd2, 1'b0, 3'd1, 1'b0);
    cyc("t2_rel",  4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 3'd7, 1'b1, 3'd0, 1'b0);
    cyc("t2_r2",   4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 3'd7, 1'b0, 3'd1, 1'b0);
    cyc("t2_r3",   4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 3'd7, 1'b0, 3'd2, 1'b0);
    cyc("t2_r4",   4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 3'd7, 1'b0, 3'd3, 1'b0);
    cyc("t2_full", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);

    // simultaneous send+return, then return while full
    cyc("t3_req",  4'h0, 4'h0, 4'h1, 1'b0, 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);
    cyc("t3_f1",   4'h1, 4'h0, 4'h0, 1'b0, 4'h1, 3'd4, 1'b0, 3'd4, 1'b0);
    cyc("t3_f2",   4'h1, 4'h0, 4'h0, 1'b0, 4'h1, 3'd4, 1'b0, 3'd3, 1'b0);
    cyc("t3_both", 4'h1, 4'h1, 4'h0, 1'b1, 4'h1, 3'd4, 1'b0, 3'd2, 1'b0);
    cyc("t3_hold", 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 3'd7, 1'b1, 3'd2, 1'b0);
    cyc("t3_r3",   4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 3'd7, 1'b0, 3'd3, 1'b0);
    cyc("t3_ovf",  4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);
    cyc("t3_err",  4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd7, 1'b0, 3'd4, 1'b1);
    cyc("t3_stk",  4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd7, 1'b0, 3'd4, 1'b1);
    do_reset();

    // bubble on l while the arbiter switches to e
    cyc("t4_req",  4'h0, 4'h0, 4'h1, 1'b0, 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);
    cyc("t4_f1",   4'h1, 4'h0, 4'h2, 1'b0, 4'h1, 3'd4, 1'b0, 3'd4, 1'b0);
    cyc("t4_bub1", 4'h2, 4'h0, 4'h2, 1'b0, 4'h0, 3'd4, 1'b0, 3'd3, 1'b0);
    cyc("t4_bub2", 4'h2, 4'h0, 4'h2, 1'b0, 4'h0, 3'd4, 1'b0, 3'd3, 1'b0);
    cyc("t4_tail", 4'h3, 4'h1, 4'h2, 1'b0, 4'h1, 3'd4, 1'b0, 3'd3, 1'b0);
    cyc("t4_rel",  4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd7, 1'b1, 3'd2, 1'b0);
    cyc("t4_idle", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd7, 1'b0, 3'd2, 1'b0);
    do_reset();

    // multi-hot grant w+e
    cyc("t5_req",  4'h0, 4'h0, 4'h6, 1'b0, 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);
    cyc("t5_f1",   4'h6, 4'h6, 4'h0, 1'b0, 4'h4, 3'd2, 1'b0, 3'd4, 1'b1);
    cyc("t5_rel",  4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd7, 1'b1, 3'd3, 1'b1);
    do_reset();

    // asynchronous reset mid-packet
    cyc("t6_req",  4'h0, 4'h0, 4'h8, 1'b0, 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);
    cyc("t6_f1",   4'h8, 4'h0, 4'h0, 1'b0, 4'h8, 3'd0, 1'b0, 3'd4, 1'b0);
    cyc("t6_f2",   4'h8, 4'h0, 4'h0, 1'b0, 4'h8, 3'd0, 1'b0, 3'd3, 1'b0);
    req_valid_i = 4'h8; req_tail_i = 4'h0; rrp_grant_i = 4'h0; credit_return_i = 1'b0;
    #2;
    reset = 1'b1;
    push_exp("t6_arst", 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);
    #1;
    compare_front();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc("t6_after", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);
    cyc("t6_quiet", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd7, 1'b0, 3'd4, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
